// File: rtl/audio_tone_sequencer.sv
// Stereo tone-sequence source for the HDMI audio path: up to 8 table-driven notes with attack/sustain/release envelope.
// Optional build macro AUDIO_TONE_TRIANGLE_EN selects a triangle waveform instead of the default square.
module audio_tone_sequencer #(
  parameter int          PHASE_W      = 24,
  parameter int          STEP_SAMPLES = 12000,
  parameter logic [15:0] AMPLITUDE    = 16'h2000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_strobe,
  input  logic               start,
  input  logic               stop,
  input  logic               tbl_we,
  input  logic [2:0]         tbl_addr,
  input  logic [PHASE_W-1:0] tbl_data,
  output logic [15:0]        left_sample,
  output logic [15:0]        right_sample,
  output logic               busy,
  output logic [2:0]         note_index
);

  localparam int                CNT_W   = $clog2(STEP_SAMPLES) + 1;
  localparam logic [CNT_W-1:0]  REL_CNT = CNT_W'(STEP_SAMPLES - 256);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [15:0]       AMP_NEG = 16'd0 - AMPLITUDE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d, eff_state_s;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         env_q, env_d;
  logic [CNT_W-1:0]   note_cnt_q, note_cnt_d;
  logic [2:0]         note_idx_q, note_idx_d, next_idx_s;
  logic               stopping_q, stopping_d, stop_now_s;
  logic [15:0]        sample_q, sample_d;
  logic               busy_q, busy_d;
  logic [PHASE_W-1:0] tbl_q [8];

  logic [15:0]        wave_s;
  logic signed [23:0] wave_ext_s, env_ext_s, prod_s, shift_s;
  logic [15:0]        sample_val_s;

`ifdef AUDIO_TONE_TRIANGLE_EN
  logic [15:0]        tri_p_s;
  logic [14:0]        tri_t_s;
  logic signed [15:0] tri_c_s;
  logic signed [31:0] tri_c_ext_s, tri_amp_s, tri_prod_s, tri_shift_s;

  // Triangle folded from the top 16 phase bits, centred on zero.
  always_comb begin
    tri_p_s = phase_q[PHASE_W-1 -: 16];
    if (tri_p_s[15]) begin
      tri_t_s = ~tri_p_s[14:0];
    end else begin
      tri_t_s = tri_p_s[14:0];
    end
    tri_c_s     = $signed({1'b0, tri_t_s}) - 16'sh4000;
    tri_c_ext_s = {{16{tri_c_s[15]}}, tri_c_s};
    tri_amp_s   = {16'd0, AMPLITUDE};
    tri_prod_s  = tri_c_ext_s * tri_amp_s;
    tri_shift_s = tri_prod_s >>> 14;
    wave_s      = tri_shift_s[15:0];
  end
`else
  // Square wave from the phase MSB.
  always_comb begin
    if (phase_q[PHASE_W-1]) begin
      wave_s = AMP_NEG;
    end else begin
      wave_s = AMPLITUDE;
    end
  end
`endif

  // Envelope scaling: signed 24-bit product, arithmetic shift, truncate.
  always_comb begin
    wave_ext_s   = {{8{wave_s[15]}}, wave_s};
    env_ext_s    = {16'd0, env_q};
    prod_s       = wave_ext_s * env_ext_s;
    shift_s      = prod_s >>> 8;
    sample_val_s = shift_s[15:0];
  end

  // Next-state logic: command handling, then per-strobe envelope stepping.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    env_d       = env_q;
    note_cnt_d  = note_cnt_q;
    note_idx_d  = note_idx_q;
    stopping_d  = stopping_q;
    sample_d    = sample_q;
    next_idx_s  = note_idx_q + 3'd1;
    stop_now_s  = stop && (state_q != ST_IDLE);
    eff_state_s = state_q;

    // A stop coincident with a strobe processes that strobe as RELEASE.
    if (stop_now_s) begin
      state_d     = ST_RELEASE;
      stopping_d  = 1'b1;
      eff_state_s = ST_RELEASE;
    end else begin
      eff_state_s = state_q;
    end

    if (state_q == ST_IDLE) begin
      if (start && (tbl_q[0] != {PHASE_W{1'b0}})) begin
        state_d    = ST_ATTACK;
        phase_d    = {PHASE_W{1'b0}};
        env_d      = 8'd0;
        note_cnt_d = {CNT_W{1'b0}};
        note_idx_d = 3'd0;
      end else begin
        state_d = ST_IDLE;
      end
      if (sample_strobe) begin
        sample_d = 16'd0;
      end else begin
        sample_d = sample_q;
      end
    end else if (sample_strobe) begin
      sample_d   = sample_val_s;
      phase_d    = phase_q + tbl_q[note_idx_q];
      note_cnt_d = note_cnt_q + CNT_ONE;
      case (eff_state_s)
        ST_ATTACK: begin
          if (env_q >= 8'd254) begin
            env_d   = 8'd255;
            state_d = ST_SUSTAIN;
          end else begin
            env_d   = env_q + 8'd1;
            state_d = ST_ATTACK;
          end
        end
        ST_SUSTAIN: begin
          if (note_cnt_q == REL_CNT) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_SUSTAIN;
          end
        end
        ST_RELEASE: begin
          // env<=1 also covers a stop issued while env is still 0.
          if (env_q <= 8'd1) begin
            env_d = 8'd0;
            if (stopping_q || stop_now_s || (note_idx_q == 3'd7) ||
                (tbl_q[next_idx_s] == {PHASE_W{1'b0}})) begin
              state_d    = ST_IDLE;
              stopping_d = 1'b0;
            end else begin
              note_idx_d = next_idx_s;
              note_cnt_d = {CNT_W{1'b0}};
              state_d    = ST_ATTACK;
            end
          end else begin
            env_d = env_q - 8'd1;
          end
        end
        default: begin
          env_d = env_q;
        end
      endcase
    end else begin
      sample_d = sample_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= {PHASE_W{1'b0}};
      env_q      <= 8'd0;
      note_cnt_q <= {CNT_W{1'b0}};
      note_idx_q <= 3'd0;
      stopping_q <= 1'b0;
      sample_q   <= 16'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      env_q      <= env_d;
      note_cnt_q <= note_cnt_d;
      note_idx_q <= note_idx_d;
      stopping_q <= stopping_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
    end
  end

  // Note table; writes are accepted on any cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= {PHASE_W{1'b0}};
      end
    end else if (tbl_we) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end

  assign left_sample  = sample_q;
  assign right_sample = sample_q;
  assign busy         = busy_q;
  assign note_index   = note_idx_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Self-checking bench for audio_tone_sequencer: per-cycle model comparison plus hand-computed sample checks.
module tb_audio_tone_sequencer;

  localparam int STEP = 600;
  localparam int AMP  = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_strobe = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_addr = 3'd0;
  logic [23:0] tbl_data = 24'd0;
  logic [15:0] left_sample, right_sample;
  logic        busy;
  logic [2:0]  note_index;

  int total = 0;
  int bad = 0;

  // Model: note-relative sample index with closed-form envelope.
  bit          m_active, m_stopped;
  int          m_note, m_k, m_j, m_stop_env;
  logic [23:0] m_phase;
  logic [15:0] m_out;
  logic [23:0] m_tbl [8];

  always #5 clk = ~clk;

  audio_tone_sequencer #(
    .PHASE_W(24),
    .STEP_SAMPLES(STEP),
    .AMPLITUDE(16'h2000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_strobe(sample_strobe),
    .start(start),
    .stop(stop),
    .tbl_we(tbl_we),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .left_sample(left_sample),
    .right_sample(right_sample),
    .busy(busy),
    .note_index(note_index)
  );

  function automatic int env_of(int k);
    int e;
    e = k;
    if (e > 255) e = 255;
    if (STEP - k < e) e = STEP - k;
    return e;
  endfunction

  function automatic logic [15:0] model_sample(logic [23:0] ph, int env);
    int w;
    int p;
`ifdef AUDIO_TONE_TRIANGLE_EN
    int pp;
    int t;
    pp = {16'd0, ph[23:8]};
    if (pp[15]) t = (~pp) & 32'h7FFF;
    else        t = pp & 32'h7FFF;
    w = ((t - 16384) * AMP) >>> 14;
`else
    if (ph[23]) w = -AMP;
    else        w = AMP;
`endif
    p = (w * env) >>> 8;
    return p[15:0];
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_stopped = 1'b0;
    m_note = 0;
    m_k = 0;
    m_j = 0;
    m_stop_env = 0;
    m_phase = 24'd0;
    m_out = 16'd0;
    for (int i = 0; i < 8; i++) m_tbl[i] = 24'd0;
  endtask

  task automatic model_update();
    int env;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_active) begin
        if (sample_strobe) m_out = 16'd0;
        if (start && m_tbl[0] != 24'd0) begin
          m_active = 1'b1;
          m_stopped = 1'b0;
          m_note = 0;
          m_k = 0;
          m_phase = 24'd0;
        end
      end else begin
        if (stop && !m_stopped) begin
          m_stopped = 1'b1;
          m_stop_env = env_of(m_k);
          m_j = 0;
        end
        if (sample_strobe) begin
          env = m_stopped ? (m_stop_env - m_j) : env_of(m_k);
          m_out = model_sample(m_phase, env);
          m_phase = m_phase + m_tbl[m_note];
          m_k++;
          if (m_stopped) begin
            m_j++;
            if (m_stop_env - m_j <= 0) m_active = 1'b0;
          end else if (m_k == STEP) begin
            if (m_note == 7 || m_tbl[m_note + 1] == 24'd0) begin
              m_active = 1'b0;
            end else begin
              m_note++;
              m_k = 0;
            end
          end
        end
      end
      if (tbl_we) m_tbl[tbl_addr] = tbl_data;
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("left", left_sample, m_out);
    chk("right", right_sample, m_out);
    chk("busy", {15'd0, busy}, {15'd0, m_active});
    chk("note_index", {13'd0, note_index}, {13'd0, m_note[2:0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic strobe(int gap);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    for (int g = 1; g < gap; g++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wr(logic [2:0] a, logic [23:0] d);
    tbl_we = 1'b1;
    tbl_addr = a;
    tbl_data = d;
    step();
    tbl_we = 1'b0;
  endtask

  initial begin
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset_left", left_sample, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);

    // Idle with empty table: silent, and start is refused.
    for (int i = 0; i < 100; i++) strobe(3);
    pulse_start();
    step();
    chk("empty_start_busy", {15'd0, busy}, 16'h0000);
    chk("idle_left", left_sample, 16'h0000);

    // Single note, square at half-rate.
    wr(3'd0, 24'h800000);
    pulse_start();
    chk("start_busy", {15'd0, busy}, 16'h0001);
    for (int i = 0; i <= 600; i++) begin
      strobe(4);
      if (i == 1)   chk("s1", left_sample, 16'hFFE0);
      if (i == 2)   chk("s2", left_sample, 16'h0040);
      if (i == 255) chk("s255", left_sample, 16'hE020);
      if (i == 256) chk("s256", left_sample, 16'h1FE0);
      if (i == 598) chk("busy_598", {15'd0, busy}, 16'h0001);
      if (i == 599) begin
        chk("s599", left_sample, 16'hFFE0);
        chk("busy_599", {15'd0, busy}, 16'h0000);
      end
      if (i == 600) chk("s600_idle", left_sample, 16'h0000);
    end

    // Two notes with back-to-back strobes.
    wr(3'd1, 24'h400000);
    pulse_start();
    for (int i = 0; i <= 602; i++) begin
      strobe(1);
      if (i == 598) chk("note_598", {13'd0, note_index}, 16'h0000);
      if (i == 599) chk("note_599", {13'd0, note_index}, 16'h0001);
      if (i == 600) chk("n1_s0", left_sample, 16'h0000);
      if (i == 601) chk("n1_s1", left_sample, 16'h0020);
      if (i == 602) chk("n1_s2", left_sample, 16'hFFC0);
    end
    pulse_stop();
    for (int i = 0; i < 5; i++) strobe(2);
    chk("n1_stop_busy", {15'd0, busy}, 16'h0000);
    chk("n1_stop_note", {13'd0, note_index}, 16'h0001);

    // Stop at sustain: 255-strobe release, then idle on note 0.
    pulse_start();
    for (int i = 0; i < 300; i++) strobe(2);
    pulse_stop();
    for (int i = 0; i < 254; i++) strobe(2);
    chk("rel_254_busy", {15'd0, busy}, 16'h0001);
    strobe(2);
    chk("rel_255_busy", {15'd0, busy}, 16'h0000);
    chk("rel_note", {13'd0, note_index}, 16'h0000);

    // Start while busy ignored; start+stop+strobe processed as release.
    pulse_start();
    for (int i = 0; i < 10; i++) strobe(2);
    pulse_start();
    for (int i = 0; i < 2; i++) strobe(2);
    start = 1'b1;
    stop = 1'b1;
    sample_strobe = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    sample_strobe = 1'b0;
    chk("stop_strobe_sample", left_sample, 16'h0180);
    for (int i = 0; i < 10; i++) strobe(2);
    chk("stop_rel_busy", {15'd0, busy}, 16'h0001);
    strobe(2);
    chk("stop_rel_idle", {15'd0, busy}, 16'h0000);

    // Start coincident with a strobe: first real sample comes next strobe.
    start = 1'b1;
    sample_strobe = 1'b1;
    step();
    start = 1'b0;
    sample_strobe = 1'b0;
    chk("cstart_left", left_sample, 16'h0000);
    chk("cstart_busy", {15'd0, busy}, 16'h0001);
    strobe(2);
    strobe(2);
    chk("cstart_s1", left_sample, 16'hFFE0);
    pulse_stop();
    for (int i = 0; i < 3; i++) strobe(2);
    chk("cstart_end", {15'd0, busy}, 16'h0000);

    // Full table: ends after note 7.
    for (int i = 0; i < 8; i++) wr(3'(i), 24'h100000 * 24'(i + 1));
    pulse_start();
    for (int i = 0; i < 8 * STEP; i++) begin
      strobe(1);
      if (i == 8 * STEP - 2) chk("full_busy", {15'd0, busy}, 16'h0001);
      if (i == 8 * STEP - 1) begin
        chk("full_idle", {15'd0, busy}, 16'h0000);
        chk("full_note", {13'd0, note_index}, 16'h0007);
      end
    end

    // Asynchronous reset mid-note.
    pulse_start();
    for (int i = 0; i < 100; i++) strobe(2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_left", left_sample, 16'h0000);
    chk("async_busy", {15'd0, busy}, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    pulse_start();
    step();
    chk("post_reset_start", {15'd0, busy}, 16'h0000);
    for (int i = 0; i < 5; i++) strobe(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
